// File: rtl/mux8_arbiter.sv
// Round-robin arbiter for 8 requesters feeding a shared 8:1 mux; grant, select and act are registered.
// Optional burst limiting with preemption is compiled in when ARB_BURST_LIMIT_EN is defined.
module mux8_arbiter #(
    parameter int MAXBURST = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [7:0] r,
    output logic [7:0] g,
    output logic [2:0] S,
    output logic       act,
    output logic       dbg_state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] k_q, k_d;
    logic [7:0] g_q, g_d;
    logic       act_q, act_d;
    logic [7:0] others;
    logic       handover;

    if (MAXBURST < 1 || MAXBURST > 255) begin : g_bad_maxburst
        $error("mux8_arbiter: MAXBURST must be within 1..255");
    end

    // First set bit of mask scanning base, base+1, ... modulo 8.
    function automatic logic [2:0] pick(input logic [2:0] base, input logic [7:0] mask);
        logic [2:0] idx;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = base + 3'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [7:0] MAXB = 8'(MAXBURST);
    logic [7:0] cnt_q, cnt_d;
    logic       preempt;
    assign preempt = r[k_q] && (cnt_q == MAXB) && (others != 8'h00);
`endif

    assign others = r & ~(8'(1) << k_q);

`ifdef ARB_BURST_LIMIT_EN
    assign handover = !r[k_q] || preempt;
`else
    assign handover = !r[k_q];
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        k_d     = k_q;
        g_d     = g_q;
        act_d   = act_q;
`ifdef ARB_BURST_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (r != 8'h00) begin
                    k_d     = pick(ptr_q, r);
                    g_d     = 8'(1) << k_d;
                    act_d   = 1'b1;
                    state_d = GRANT;
`ifdef ARB_BURST_LIMIT_EN
                    cnt_d   = 8'd1;
`endif
                end
            end
            GRANT: begin
                if (handover) begin
                    // The outgoing owner drops to lowest priority whether it released or was preempted.
                    ptr_d = k_q + 3'd1;
                    if (others != 8'h00) begin
                        k_d = pick(k_q + 3'd1, others);
                        g_d = 8'(1) << k_d;
`ifdef ARB_BURST_LIMIT_EN
                        cnt_d = 8'd1;
`endif
                    end else begin
                        g_d     = 8'h00;
                        act_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
`ifdef ARB_BURST_LIMIT_EN
                    if (cnt_q != MAXB) begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            k_q     <= 3'd0;
            g_q     <= 8'h00;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            k_q     <= k_d;
            g_q     <= g_d;
            act_q   <= act_d;
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign g           = g_q;
    assign S           = k_q;
    assign act         = act_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/mux8_arbiter.md
# mux8_arbiter

Round-robin arbiter for 8 requesters that share one 8:1 single-bit multiplexer channel. Samples request lines, issues a registered one-hot grant, and drives the multiplexer's 3-bit select so that the granted requester's data reaches the shared output. Sits directly in front of the 8:1 mux, with `S` wired to its select input.

## Interface
- `MAXBURST`, default 4: maximum consecutive grant cycles while others wait. Legal range 1..255. Used only when `ARB_BURST_LIMIT_EN` is defined.
- `Clock  input  1`: single clock. All state updates on the rising edge.
- `Resetn  input  1`: reset, asynchronous, active-low.
- `r  input  8`: request lines. `r[i]` is requester i, level-sensitive.
- `g  output  8`: registered one-hot grant. All zeros when nothing is granted.
- `S  output  3`: registered mux select, the index of the granted requester.
- `act  output  1`: registered; 1 while any grant is active, equal to `|g`.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - Priority pointer `ptr[2:0]`.
  - Owner index `k[2:0]`, which drives `S`.
  - Burst counter `cnt[7:0]`, present only when `ARB_BURST_LIMIT_EN` is defined.
- Search function `pick(base, mask)`: returns the first set bit of `mask`, scanning `base, base+1, …, 7, 0, …, base-1` (modulo 8).
- In IDLE:
  - If `r != 0`: set `k = pick(ptr, r)`, `g = 1<<k`, `S = k`, `act = 1`, `cnt = 1`. Go to GRANT.
  - Otherwise remain in IDLE.
- In GRANT, release case (`r[k] == 0`):
  - Set `ptr = k+1` (wraps 7→0).
  - Let `m = r & ~(1<<k)`. If `m != 0`: hand over directly in the same edge (new `k = pick(k+1, m)`, `g`/`S` updated, `cnt = 1`), staying in GRANT. There is no dead cycle.
  - Otherwise: `g = 0`, `act = 0`, go to IDLE.
- In GRANT, hold case (`r[k] == 1`): grant holds. With the macro defined, `cnt` increments, saturating at `MAXBURST`.
- `S` retains the last owner's index in IDLE; it is not cleared.
- Fairness: a released or preempted requester becomes lowest priority, because `ptr` is set to `k+1`.
- Requests that rise and fall while another requester owns the grant are not remembered. There is no request latching.

## Timing
- Reset values (asynchronous, immediate on `Resetn = 0`): `g = 8'h00`, `S = 3'd0`, `act = 0`, `ptr = 0`, `k = 0`, `cnt = 0`, state IDLE.
- Reset asserted mid-grant drops the grant immediately. After release, the first edge with `r != 0` grants from `ptr = 0`.
- Latency is 1 cycle: `r` sampled at edge N, so `g`/`S`/`act` are valid after edge N.
- Release is also 1 cycle: after the edge that samples `r[k] = 0`, the old grant is gone.
- Handover: the old and new grants are never both high. `g` switches one-hot to one-hot on a single edge.
- Multiple requests rising simultaneously in IDLE: the lowest index at or after `ptr` (modulo 8) wins.

## Configuration
- Macro `ARB_BURST_LIMIT_EN`.
- Defined: enables `cnt` and preemption.
  - Preemption condition: state GRANT, `r[k] = 1`, `cnt == MAXBURST`, and `m != 0`.
  - When the condition holds, the edge performs a handover exactly as in a release: `ptr = k+1`, new owner from `pick(k+1, m)`, `cnt = 1`.
  - Result: an owner holds for at most `MAXBURST` cycles when others are waiting.
  - With no other request pending, `cnt` saturates and the grant continues indefinitely.
- Undefined: no counter logic. The owner holds for as long as `r[k] = 1`, and `MAXBURST` is ignored.

## Test plan
- Reset: `Resetn = 0` with `r = 8'hFF`. Expect `g = 0`, `S = 0`, `act = 0`. Release reset; one edge later `g = 8'h01`, `S = 0`.
- Rotation: hold `r = 8'hFF`, each owner dropping its request for one cycle after each grant. Expect grant order 0,1,2,…,7,0 with `S` tracking it and one owner per edge.
- Wrap/priority: reach `ptr = 6` (owner 5 released), then apply `r = 8'h21`. Expect `g = 8'h01` (`S = 0`), not bit 5.
- Handover: owner 2 holds; set `r = 8'h14`, then drop bit 2. Next edge `g = 8'h10`, `S = 4`, and `act` stays 1 throughout.
- Idle hold: a single requester 3 releases with `r = 0`. Expect `g = 0`, `act = 0`, `S` remains 3.
- Burst limit (macro defined, `MAXBURST = 4`): with `r = 8'h03` constant, expect `g = 8'h01` for 4 cycles, then `8'h02` for 4 cycles, alternating. With the macro undefined, expect `g = 8'h01` indefinitely.
